// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: assembles 16-bit instructions from a high-byte-first byte
// stream and buffers them in a DEPTH-entry FIFO with a valid/ready output port.
// Optional build macro FETCH_DROP_NOP_EN: discard assembled opcode-0 instructions.
module instr_fetch_queue #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          flush,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   output logic          byte_ready,
   output logic [15:0]   instr_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [CW-1:0] count,
   output logic          illegal
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_t;

   phase_t        phase_q, phase_d;
   logic [7:0]    hi_hold_q;
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          illegal_q;

   logic          full, empty;
   logic          byte_take, hi_load, word_done;
   logic          drop, push, pop;
   logic [15:0]   assembled;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == CW'(0));
   assign byte_take = byte_valid && byte_ready;
   assign assembled = {hi_hold_q, byte_in};

`ifdef FETCH_DROP_NOP_EN
   assign drop = (assembled[15:12] == 4'h0);
`else
   assign drop = 1'b0;
`endif

   assign push = word_done && !drop;
   assign pop  = instr_valid && instr_ready && !flush;

   // Phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= PH_HI;
      else        phase_q <= phase_d;
   end

   // Phase next state: toggle on every accepted byte, flush returns to HI
   always_comb begin
      phase_d = phase_q;
      if (flush)
         phase_d = PH_HI;
      else if (byte_take)
         phase_d = (phase_q == PH_HI) ? PH_LO : PH_HI;
   end

   // Phase outputs: byte acceptance and which half of the word is landing
   always_comb begin
      byte_ready = 1'b0;
      hi_load    = 1'b0;
      word_done  = 1'b0;
      byte_ready = ena && !flush && ((phase_q == PH_HI) || !full);
      if (byte_take) begin
         hi_load   = (phase_q == PH_HI);
         word_done = (phase_q == PH_LO);
      end
   end

   // High-byte holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       hi_hold_q <= 8'h00;
      else if (flush)   hi_hold_q <= 8'h00;
      else if (hi_load) hi_hold_q <= byte_in;
   end

   // FIFO storage (no reset needed, contents gated by count)
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= assembled;
   end

   // FIFO pointers, occupancy and sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (word_done && assembled[15]) illegal_q <= 1'b1;
      end
   end

   assign instr_valid = ena && !empty;
   assign instr_out   = empty ? 16'h0000 : mem_q[rd_ptr_q];
   assign count       = count_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef FETCH_DROP_NOP_EN
   localparam bit DROP_NOP = 1'b1;
`else
   localparam bit DROP_NOP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, ena, flush, byte_valid, instr_ready;
   logic [7:0]    byte_in;
   logic          byte_ready, instr_valid, illegal;
   logic [15:0]   instr_out;
   logic [CW-1:0] count;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: instruction queue, phase, held high byte, sticky flag
   logic [15:0] mq[$];
   bit          m_lo;
   logic [7:0]  m_hi;
   bit          m_ill;

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .count(count), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic bit p_ready();
      return ena && !flush && (!m_lo || mq.size() < DEPTH);
   endfunction

   function automatic bit p_valid();
      return ena && (mq.size() != 0);
   endfunction

   function automatic logic [15:0] p_out();
      return (mq.size() != 0) ? mq[0] : 16'h0000;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_lo  = 1'b0;
      m_hi  = 8'h00;
      m_ill = 1'b0;
   endtask

   task automatic drive(input logic e, input logic f, input logic bv,
                        input logic [7:0] b, input logic ir);
      ena = e; flush = f; byte_valid = bv; byte_in = b; instr_ready = ir;
   endtask

   // advance the model with the current inputs, then clock the DUT
   task automatic tick();
      bit          take, pop;
      logic [15:0] w;
      pop  = p_valid() && instr_ready && !flush;
      take = byte_valid && p_ready();
      if (flush) begin
         model_clear();
      end else begin
         if (pop) void'(mq.pop_front());
         if (take) begin
            if (!m_lo) begin
               m_hi = byte_in;
               m_lo = 1'b1;
            end else begin
               w = {m_hi, byte_in};
               if (w[15]) m_ill = 1'b1;
               if (!(DROP_NOP && w[15:12] == 4'h0)) mq.push_back(w);
               m_lo = 1'b0;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [15:0] w, input logic ir);
      drive(1, 0, 1, w[15:8], ir); tick();
      drive(1, 0, 1, w[7:0], ir);  tick();
      drive(1, 0, 0, 8'h00, ir);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
         drive(1, 0, 0, 8'h00, 1); tick();
      end
      drive(1, 0, 0, 8'h00, 0);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 8'h00, 0);
      rst_n = 1'b0;
      model_clear();
      #2;
      n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
      n_cmp++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h want=0000", instr_out); end
      n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b want=0", illegal); end
      n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_byte_ready got=%b want=1", byte_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      drive(1, 0, 1, 8'h13, 1); #1;
      n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b want=1", byte_ready); end
      tick();
      drive(1, 0, 1, 8'h5A, 1); #1;
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got=%b want=0", instr_valid); end
      tick();
      drive(1, 0, 0, 8'h00, 1); #1;
      n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b want=1", instr_valid); end
      n_cmp++; if (instr_out !== 16'h135A) begin n_fail++; $display("FAIL basic_out got=%h want=135a", instr_out); end
      n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL basic_count1 got=%0d want=1", count); end
      tick();
      n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL basic_count0 got=%0d want=0", count); end
   endtask

   task automatic test_full();
      logic [15:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = {4'(1 + $urandom % 7), 12'($urandom)};
         send_word(w, 0);
      end
      #1;
      n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got=%0d want=%0d", count, DEPTH); end
      drive(1, 0, 1, 8'h3C, 0); #1;
      n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL full_hi_ready got=%b want=1", byte_ready); end
      tick();
      drive(1, 0, 1, 8'hD2, 0); #1;
      n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL full_lo_blocked got=%b want=0", byte_ready); end
      tick();
      drive(1, 0, 1, 8'hD2, 1); #1;
      n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_space got=%b want=0", byte_ready); end
      tick();
      n_cmp++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL full_after_pop got=%0d want=%0d", count, DEPTH - 1); end
      drive(1, 0, 1, 8'hD2, 0); #1;
      n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL full_lo_ready got=%b want=1", byte_ready); end
      tick();
      n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_refill got=%0d want=%0d", count, DEPTH); end
      for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
         drive(1, 0, 0, 8'h00, 1); #1;
         n_cmp++; if (instr_out !== p_out()) begin n_fail++; $display("FAIL full_drain_out got=%h want=%h", instr_out, p_out()); end
         tick();
      end
      drive(1, 0, 0, 8'h00, 0);
   endtask

   task automatic test_wrap();
      logic [15:0] words[10];
      logic [7:0]  bytes[20];
      logic [15:0] got[$];
      int          bi = 0;
      for (int i = 0; i < 10; i++) begin
         words[i]       = {4'(1 + i % 7), 4'(i), 8'($urandom)};
         bytes[2*i]     = words[i][15:8];
         bytes[2*i + 1] = words[i][7:0];
      end
      for (int cyc = 0; cyc < 200 && !(bi == 20 && got.size() == 10); cyc++) begin
         drive(1, 0, bi < 20, (bi < 20) ? bytes[bi] : 8'h00, cyc[0]); #1;
         n_cmp++; if (count > CW'(DEPTH)) begin n_fail++; $display("FAIL wrap_count_bound got=%0d want<=%0d", count, DEPTH); end
         n_cmp++; if (instr_out !== p_out()) begin n_fail++; $display("FAIL wrap_out got=%h want=%h", instr_out, p_out()); end
         if (instr_valid && instr_ready) got.push_back(instr_out);
         if (byte_valid && p_ready()) bi++;
         tick();
      end
      n_cmp++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_num_out got=%0d want=10", got.size()); end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== words[i]) begin n_fail++; $display("FAIL wrap_order idx=%0d got=%h want=%h", i, got[i], words[i]); end
      end
      drain();
   endtask

   task automatic test_illegal_flush();
      drive(1, 0, 1, 8'h81, 0); tick();
      n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_early got=%b want=0", illegal); end
      drive(1, 0, 1, 8'h23, 0); tick();
      drive(1, 0, 0, 8'h00, 0); #1;
      n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_set got=%b want=1", illegal); end
      n_cmp++; if (instr_out !== 16'h8123) begin n_fail++; $display("FAIL ill_forward got=%h want=8123", instr_out); end
      send_word(16'h1567, 0);
      drive(1, 0, 1, 8'h77, 0); tick();
      #1;
      n_cmp++; if (count !== CW'(2)) begin n_fail++; $display("FAIL flush_pre_count got=%0d want=2", count); end
      drive(1, 1, 1, 8'h99, 1); #1;
      n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b want=0", byte_ready); end
      tick();
      drive(1, 0, 0, 8'h00, 0); #1;
      n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL flush_count got=%0d want=0", count); end
      n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL flush_illegal got=%b want=0", illegal); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b want=0", instr_valid); end
      send_word(16'h2ABC, 0); #1;
      n_cmp++; if (instr_out !== 16'h2ABC) begin n_fail++; $display("FAIL flush_fresh got=%h want=2abc", instr_out); end
   endtask

   task automatic test_async_reset();
      drive(1, 0, 1, 8'h21, 0); tick();
      drive(1, 0, 0, 8'h00, 0); #1;
      n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL arst_pre_count got=%0d want=1", count); end
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL arst_count got=%0d want=0", count); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b want=0", instr_valid); end
      n_cmp++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL arst_out got=%h want=0000", instr_out); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(16'h3456, 0); #1;
      n_cmp++; if (instr_out !== 16'h3456) begin n_fail++; $display("FAIL arst_fresh got=%h want=3456", instr_out); end
      drain();
   endtask

   task automatic test_nop();
      int          peak = 0;
      logic [15:0] seen[$];
      logic [7:0]  seq[4] = '{8'h00, 8'h00, 8'h12, 8'h07};
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, seq[i], 0); tick();
         if (int'(count) > peak) peak = int'(count);
      end
      n_cmp++; if (peak != (DROP_NOP ? 1 : 2)) begin n_fail++; $display("FAIL nop_peak got=%0d want=%0d", peak, DROP_NOP ? 1 : 2); end
      for (int i = 0; i < 4 && mq.size() != 0; i++) begin
         drive(1, 0, 0, 8'h00, 1); #1;
         seen.push_back(instr_out);
         tick();
      end
      n_cmp++; if (seen.size() != (DROP_NOP ? 1 : 2)) begin n_fail++; $display("FAIL nop_num got=%0d want=%0d", seen.size(), DROP_NOP ? 1 : 2); end
      n_cmp++; if (seen.size() == 0 || seen[0] !== (DROP_NOP ? 16'h1207 : 16'h0000)) begin
         n_fail++; $display("FAIL nop_first got=%h want=%h", (seen.size() != 0) ? seen[0] : 16'hxxxx, DROP_NOP ? 16'h1207 : 16'h0000); end
      n_cmp++; if (seen.size() == 0 || seen[seen.size()-1] !== 16'h1207) begin
         n_fail++; $display("FAIL nop_last got=%h want=1207", (seen.size() != 0) ? seen[seen.size()-1] : 16'hxxxx); end
      drive(1, 0, 0, 8'h00, 0);
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         drive(($urandom % 8) != 0, ($urandom % 32) == 0, $urandom % 2, 8'($urandom), ($urandom % 3) != 0);
         #1;
         n_cmp++; if (byte_ready !== p_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, byte_ready, p_ready()); end
         n_cmp++; if (instr_valid !== p_valid()) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, instr_valid, p_valid()); end
         n_cmp++; if (instr_out !== p_out()) begin n_fail++; $display("FAIL rnd_out cyc=%0d got=%h want=%h", cyc, instr_out, p_out()); end
         n_cmp++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, count, mq.size()); end
         n_cmp++; if (illegal !== m_ill) begin n_fail++; $display("FAIL rnd_illegal cyc=%0d got=%b want=%b", cyc, illegal, m_ill); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_illegal_flush();
      test_async_reset();
      test_nop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
